mips_multicycle_cpu: RTL and testbench
======================================

MIPS_MULTICYCLE_CPU -- requirements
Module: mips_multicycle_cpu

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter ADDR_W, default 32, range 8..32, meaning the width of mem_addr (the PC and ALU results are truncated to their low ADDR_W bits).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port mem_req, output, 1 bit: unified memory request.
REQ-006 The block SHALL have port mem_we, output, 1 bit: write strobe, meaningful only while mem_req=1.
REQ-007 The block SHALL have port mem_addr, output, ADDR_W bits: byte address.
REQ-008 The block SHALL have port mem_wdata, output, 32 bits: store data.
REQ-009 The block SHALL have port mem_rdata, input, 32 bits: read data, valid in the cycle mem_ready=1.
REQ-010 The block SHALL have port mem_ready, input, 1 bit: transfer completes on the rising edge at which mem_req=1 and mem_ready=1.
REQ-011 The block SHALL have port halted, output, 1 bit: core is stopped in state HALT.
REQ-012 The block SHALL have port pc_debug, output, 32 bits: current PC.
REQ-013 The block SHALL have port state_debug, output, 3 bits: FSM state encoding FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.

Function
REQ-014 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB and HALT; every state lasts 1 cycle, except FETCH and MEM, which persist until the handshake completes.
REQ-015 In FETCH the block SHALL drive mem_req=1, mem_we=0 and mem_addr=PC; on completion it SHALL latch mem_rdata into the IR, set PC=PC+4 and go to DECODE.
REQ-016 In DECODE the block SHALL latch rs/rt into the A/B registers and the extended immediate; an unsupported opcode/funct, or funct 0x0D (break), SHALL go to HALT.
REQ-017 The supported set SHALL be add, sub, and, or, xor, slt, sll, srl, addi, andi, ori, lw, sw, beq and j; addi/lw/sw/beq SHALL sign-extend the immediate, andi/ori SHALL zero-extend it.
REQ-018 Arithmetic SHALL be 32-bit modulo with no overflow trap; slt SHALL compare signed; shifts SHALL use shamt[10:6] applied to rt.
REQ-019 From EXEC, R-type and ALU-immediate instructions SHALL go to WB, lw/sw SHALL go to MEM, and beq/j SHALL go to FETCH.
REQ-020 In EXEC, beq SHALL set PC=PC+(simm<<2) only if A==B; j SHALL set PC={PC[31:28],IR[25:0],2'b00}.
REQ-021 In MEM the block SHALL drive mem_addr=A+simm, mem_we=1 for sw with mem_wdata=B; lw SHALL latch mem_rdata on completion and go to WB, sw SHALL go to FETCH.
REQ-022 A lw/sw effective address with addr[1:0]!=0 SHALL go to HALT from EXEC without asserting mem_req.
REQ-023 WB SHALL write rd (R-type) or rt (I-type) and go to FETCH; writes to $0 SHALL be discarded and $0 SHALL read 0.
REQ-024 Latency with zero wait states SHALL be: R/ALU-immediate 4 cycles, lw 5, sw 4, beq/j 3; each wait cycle of mem_ready=0 SHALL add exactly 1 cycle.
REQ-025 While mem_req=1 and mem_ready=0, mem_addr, mem_we and mem_wdata SHALL remain stable.
REQ-026 mem_req SHALL be 0 in DECODE, EXEC, WB and HALT.
REQ-027 HALT SHALL be exited only by reset; in HALT, halted=1 and the PC SHALL freeze at the address following the faulting instruction.

Reset
REQ-028 Reset SHALL asynchronously set state=FETCH, PC=RESET_PC, IR=0, all 31 registers=0, and force mem_req=0, mem_we=0 and halted=0 while reset is asserted.
REQ-029 Reset asserted during a pending transfer SHALL abandon it with mem_req low in the same cycle; the first request after reset release SHALL be a fetch at RESET_PC.

Configuration
REQ-030 With MIPS_MC_PERF_EN defined, the block SHALL add outputs cycle_count[31:0] (increments every non-reset cycle, including HALT) and instret_count[31:0] (increments on each transition into FETCH from EXEC, MEM or WB), both reset to 0 and wrapping modulo 2^32.
REQ-031 Without MIPS_MC_PERF_EN, those ports and counters SHALL be absent, and behaviour otherwise SHALL be identical.

Verification
REQ-032 Release reset with RESET_PC=0x100 and mem_ready tied 1 -> first mem_req with mem_addr=0x100 and mem_we=0 in the first cycle after release.
REQ-033 addi $1,$0,-5 then add $2,$1,$1 -> $2=0xFFFF_FFF6 after 8 cycles with zero wait states.
REQ-034 sw $2,8($0) with mem_ready held 0 for 3 cycles -> mem_addr=0x8, mem_we=1 and mem_wdata=0xFFFF_FFF6 stable for 4 cycles; the instruction completes in 7 cycles.
REQ-035 beq $0,$0,-1 at 0x10 -> next fetch at 0x10 (loop); lw $3,2($0) -> halted=1 with mem_req never asserted in MEM.
REQ-036 Assert reset while FETCH is stalled (mem_ready=0) -> mem_req=0 immediately, registers=0, and refetch at RESET_PC after release.
REQ-037 With MIPS_MC_PERF_EN, run 3 zero-wait add instructions then break -> instret_count=3 and cycle_count increments every cycle while halted.

Source files
------------

// File: rtl/mips_multicycle_cpu.sv
// Multicycle MIPS subset core with a unified, ready-handshaked memory port.
// Optional performance counters are enabled by defining MIPS_MC_PERF_EN.
module mips_multicycle_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [31:0]       pc_debug,
  output logic [2:0]        state_debug
`ifdef MIPS_MC_PERF_EN
  ,
  output logic [31:0]       cycle_count,
  output logic [31:0]       instret_count
`endif
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnSll = 6'h00;
  localparam logic [5:0] FnSrl = 6'h02;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnXor = 6'h26;
  localparam logic [5:0] FnSlt = 6'h2A;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] imm_q;
  logic [31:0] alu_q;
  logic [31:0] mdr_q;
  logic [31:0] regs [1:31];

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [4:0]  wb_idx;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm_ext;
  logic [31:0] alu_res;
  logic [31:0] wb_data;
  logic        legal;
  logic        is_mem_op;
  logic        retire;

  assign op     = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];
  assign wb_idx = (op == OpRtype) ? rd : rt;

  assign rs_val  = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign rt_val  = (rt == 5'd0) ? 32'd0 : regs[rt];
  assign imm_ext = (op == OpAndi || op == OpOri) ? {16'd0, ir_q[15:0]}
                                                 : {{16{ir_q[15]}}, ir_q[15:0]};
  assign wb_data   = (op == OpLw) ? mdr_q : alu_q;
  assign is_mem_op = (op == OpLw) || (op == OpSw);

  always_comb begin
    legal = 1'b0;
    case (op)
      OpRtype: begin
        case (funct)
          FnAdd, FnSub, FnAnd, FnOr, FnXor, FnSlt, FnSll, FnSrl: legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OpAddi, OpAndi, OpOri, OpLw, OpSw, OpBeq, OpJ: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = a_q + imm_q;
    case (op)
      OpRtype: begin
        case (funct)
          FnAdd:   alu_res = a_q + b_q;
          FnSub:   alu_res = a_q - b_q;
          FnAnd:   alu_res = a_q & b_q;
          FnOr:    alu_res = a_q | b_q;
          FnXor:   alu_res = a_q ^ b_q;
          FnSlt:   alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
          FnSll:   alu_res = b_q << shamt;
          FnSrl:   alu_res = b_q >> shamt;
          default: alu_res = 32'd0;
        endcase
      end
      OpAndi:  alu_res = a_q & imm_q;
      OpOri:   alu_res = a_q | imm_q;
      default: alu_res = a_q + imm_q;
    endcase
  end

  // Cycles that hand control back to FETCH from EXEC, MEM or WB.
  assign retire = ((state_q == StExec) && (op == OpBeq || op == OpJ)) ||
                  ((state_q == StMem) && mem_ready && (op == OpSw)) ||
                  (state_q == StWb);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      imm_q   <= 32'd0;
      alu_q   <= 32'd0;
      mdr_q   <= 32'd0;
      for (int i = 1; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
`ifdef MIPS_MC_PERF_EN
      cycle_count   <= 32'd0;
      instret_count <= 32'd0;
`endif
    end else begin
`ifdef MIPS_MC_PERF_EN
      cycle_count <= cycle_count + 32'd1;
      if (retire) instret_count <= instret_count + 32'd1;
`endif
      case (state_q)
        StFetch: begin
          if (mem_ready) begin
            ir_q    <= mem_rdata;
            pc_q    <= pc_q + 32'd4;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          a_q     <= rs_val;
          b_q     <= rt_val;
          imm_q   <= imm_ext;
          state_q <= legal ? StExec : StHalt;
        end
        StExec: begin
          alu_q <= alu_res;
          if (is_mem_op) begin
            // Misaligned accesses stop the core before any bus request.
            state_q <= (alu_res[1:0] != 2'b00) ? StHalt : StMem;
          end else if (op == OpBeq) begin
            if (a_q == b_q) pc_q <= pc_q + (imm_q << 2);
            state_q <= StFetch;
          end else if (op == OpJ) begin
            pc_q    <= {pc_q[31:28], ir_q[25:0], 2'b00};
            state_q <= StFetch;
          end else begin
            state_q <= StWb;
          end
        end
        StMem: begin
          if (mem_ready) begin
            if (op == OpLw) begin
              mdr_q   <= mem_rdata;
              state_q <= StWb;
            end else begin
              state_q <= StFetch;
            end
          end
        end
        StWb: begin
          if (wb_idx != 5'd0) regs[wb_idx] <= wb_data;
          state_q <= StFetch;
        end
        default: state_q <= StHalt;
      endcase
    end
  end

  // Bus strobes are gated by reset so a pending transfer drops immediately.
  assign mem_req     = !reset && (state_q == StFetch || state_q == StMem);
  assign mem_we      = !reset && (state_q == StMem) && (op == OpSw);
  assign mem_addr    = (state_q == StMem) ? alu_q[ADDR_W-1:0] : pc_q[ADDR_W-1:0];
  assign mem_wdata   = b_q;
  assign halted      = (state_q == StHalt);
  assign pc_debug    = pc_q;
  assign state_debug = state_q;

endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// Directed self-checking bench for mips_multicycle_cpu with a word-addressed memory model.
module tb_mips_multicycle_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        ready = 1'b1;
  logic        halted;
  logic [31:0] pc_debug;
  logic [2:0]  state_debug;
`ifdef MIPS_MC_PERF_EN
  logic [31:0] cycle_count;
  logic [31:0] instret_count;
`endif

  logic [31:0] mem [0:255];
  int n_vec = 0;
  int n_err = 0;

  logic [31:0] prog_alu [27] = '{
    32'h2001FFFB, 32'h00211020, 32'hAC020008, 32'h20031234, 32'h3464F000,
    32'h30258FFF, 32'h00613022, 32'h00643826, 32'h0023402A, 32'h00034900,
    32'h00015702, 32'h00A65825, 32'h00246024, 32'h20000007, 32'hAC040200,
    32'hAC050204, 32'hAC060208, 32'hAC07020C, 32'hAC080210, 32'hAC090214,
    32'hAC0A0218, 32'hAC0B021C, 32'hAC0C0220, 32'hAC000224, 32'h8C0D0008,
    32'hAC0D0228, 32'h0000000D
  };
  logic [31:0] exp_alu [11] = '{
    32'h0000F234, 32'h00008FFB, 32'h00001239, 32'h0000E000, 32'h00000001,
    32'h00012340, 32'h0000000F, 32'h00009FFB, 32'h0000F230, 32'h00000000,
    32'hFFFFFFF6
  };

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];

  mips_multicycle_cpu #(
    .RESET_PC (32'h0000_0100),
    .ADDR_W   (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ready     (ready),
    .halted        (halted),
    .pc_debug      (pc_debug),
    .state_debug   (state_debug)
`ifdef MIPS_MC_PERF_EN
    ,
    .cycle_count   (cycle_count),
    .instret_count (instret_count)
`endif
  );

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_BEEF;
  endtask

  // Store writes happen at the negedge preceding the completing rising edge.
  task automatic tick();
    if (mem_req && ready && mem_we) mem[mem_addr[9:2]] = mem_wdata;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    clear_mem();
    for (int i = 0; i < 27; i++) mem[64 + i] = prog_alu[i];
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({mem_req, mem_we, halted} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_strobes: got %b want 000", {mem_req, mem_we, halted});
    end
    n_vec++;
    if (pc_debug !== 32'h100 || state_debug !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state: got pc=%h st=%0d want pc=00000100 st=0", pc_debug,
               state_debug);
    end
    ready = 1'b1;
    reset = 1'b0;
    #1;
    n_vec++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
      n_err++;
      $display("FAIL first_fetch: got req=%b we=%b addr=%h want 1 0 00000100", mem_req,
               mem_we, mem_addr);
    end
  endtask

  task automatic test_alu();
    bit done;
    clear_mem();
    for (int i = 0; i < 27; i++) mem[64 + i] = prog_alu[i];
    ready = 1'b1;
    apply_reset();
    repeat (4) tick();
    n_vec++;
    if (pc_debug !== 32'h104 || state_debug !== 3'd0) begin
      n_err++;
      $display("FAIL rtype_latency: got pc=%h st=%0d want 00000104 0", pc_debug, state_debug);
    end
    repeat (4) tick();
    n_vec++;
    if (pc_debug !== 32'h108 || mem_addr !== 32'h108 || state_debug !== 3'd0) begin
      n_err++;
      $display("FAIL eight_cycles: got pc=%h addr=%h st=%0d want 00000108 00000108 0",
               pc_debug, mem_addr, state_debug);
    end
    repeat (3) tick();
    n_vec++;
    if (state_debug !== 3'd3 || mem_we !== 1'b1 || mem_addr !== 32'h8 ||
        mem_wdata !== 32'hFFFF_FFF6) begin
      n_err++;
      $display("FAIL add_result: got st=%0d we=%b addr=%h wdata=%h want 3 1 00000008 fffffff6",
               state_debug, mem_we, mem_addr, mem_wdata);
    end
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      tick();
      done = halted;
    end
    n_vec++;
    if (!done || pc_debug !== 32'h16C) begin
      n_err++;
      $display("FAIL alu_halt: got halted=%b pc=%h want 1 0000016c", halted, pc_debug);
    end
    for (int i = 0; i < 11; i++) begin
      n_vec++;
      if (mem[128 + i] !== exp_alu[i]) begin
        n_err++;
        $display("FAIL alu_word%0d: got %h want %h", i, mem[128 + i], exp_alu[i]);
      end
    end
    n_vec++;
    if (mem[2] !== 32'hFFFF_FFF6) begin
      n_err++;
      $display("FAIL sw_word8: got %h want fffffff6", mem[2]);
    end
  endtask

  task automatic test_wait_states();
    clear_mem();
    mem[64] = 32'h2002FFF6;
    mem[65] = 32'hAC020008;
    mem[66] = 32'h0000000D;
    ready = 1'b1;
    apply_reset();
    repeat (4) tick();
    tick();
    n_vec++;
    if (state_debug !== 3'd1 || mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL decode_no_req: got st=%0d req=%b want 1 0", state_debug, mem_req);
    end
    tick();
    n_vec++;
    if (state_debug !== 3'd2 || mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL exec_no_req: got st=%0d req=%b want 2 0", state_debug, mem_req);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      ready = (i == 3);
      n_vec++;
      if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h8, 32'hFFFF_FFF6}) begin
        n_err++;
        $display("FAIL sw_stall%0d: got req=%b we=%b addr=%h wdata=%h want 1 1 00000008 fffffff6",
                 i, mem_req, mem_we, mem_addr, mem_wdata);
      end
      tick();
    end
    n_vec++;
    if (state_debug !== 3'd0 || pc_debug !== 32'h108 || mem[2] !== 32'hFFFF_FFF6) begin
      n_err++;
      $display("FAIL sw_seven_cycles: got st=%0d pc=%h mem=%h want 0 00000108 fffffff6",
               state_debug, pc_debug, mem[2]);
    end
    ready = 1'b0;
    repeat (2) tick();
    n_vec++;
    if (state_debug !== 3'd0 || mem_req !== 1'b1 || mem_addr !== 32'h108) begin
      n_err++;
      $display("FAIL fetch_stall: got st=%0d req=%b addr=%h want 0 1 00000108", state_debug,
               mem_req, mem_addr);
    end
    ready = 1'b1;
    repeat (2) tick();
    n_vec++;
    if (halted !== 1'b1 || state_debug !== 3'd5 || pc_debug !== 32'h10C) begin
      n_err++;
      $display("FAIL break_halt: got h=%b st=%0d pc=%h want 1 5 0000010c", halted,
               state_debug, pc_debug);
    end
  endtask

  task automatic test_branch();
    clear_mem();
    mem[64] = 32'h08000004;
    mem[4]  = 32'h1000FFFF;
    ready = 1'b1;
    apply_reset();
    repeat (3) tick();
    n_vec++;
    if (state_debug !== 3'd0 || pc_debug !== 32'h10 || mem_addr !== 32'h10) begin
      n_err++;
      $display("FAIL jump_target: got st=%0d pc=%h addr=%h want 0 00000010 00000010",
               state_debug, pc_debug, mem_addr);
    end
    repeat (3) tick();
    n_vec++;
    if (state_debug !== 3'd0 || pc_debug !== 32'h10) begin
      n_err++;
      $display("FAIL beq_loop1: got st=%0d pc=%h want 0 00000010", state_debug, pc_debug);
    end
    repeat (3) tick();
    n_vec++;
    if (state_debug !== 3'd0 || pc_debug !== 32'h10 || halted !== 1'b0) begin
      n_err++;
      $display("FAIL beq_loop2: got st=%0d pc=%h h=%b want 0 00000010 0", state_debug,
               pc_debug, halted);
    end
  endtask

  task automatic test_faults();
    bit seen_req;
    clear_mem();
    mem[64] = 32'h8C030002;
    ready = 1'b1;
    apply_reset();
    tick();
    seen_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen_req |= mem_req;
      tick();
    end
    n_vec++;
    if (seen_req !== 1'b0) begin
      n_err++;
      $display("FAIL misaligned_req: got req_seen=%b want 0", seen_req);
    end
    n_vec++;
    if (halted !== 1'b1 || state_debug !== 3'd5 || pc_debug !== 32'h104) begin
      n_err++;
      $display("FAIL misaligned_halt: got h=%b st=%0d pc=%h want 1 5 00000104", halted,
               state_debug, pc_debug);
    end
    clear_mem();
    mem[64] = 32'hFC000000;
    apply_reset();
    repeat (2) tick();
    n_vec++;
    if (halted !== 1'b1 || pc_debug !== 32'h104 || mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL illegal_halt: got h=%b pc=%h req=%b want 1 00000104 0", halted,
               pc_debug, mem_req);
    end
  endtask

  task automatic test_reset_stall();
    bit done;
    clear_mem();
    for (int i = 0; i < 27; i++) mem[64 + i] = prog_alu[i];
    ready = 1'b1;
    apply_reset();
    repeat (8) tick();
    ready = 1'b0;
    repeat (2) tick();
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({mem_req, mem_we} !== 2'b00 || pc_debug !== 32'h100 || state_debug !== 3'd0) begin
      n_err++;
      $display("FAIL async_reset: got req=%b we=%b pc=%h st=%0d want 0 0 00000100 0",
               mem_req, mem_we, pc_debug, state_debug);
    end
    clear_mem();
    mem[64] = 32'hAC010300;
    mem[65] = 32'hAC020304;
    mem[66] = 32'h0000000D;
    @(negedge clk);
    ready = 1'b1;
    reset = 1'b0;
    #1;
    n_vec++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
      n_err++;
      $display("FAIL refetch: got req=%b addr=%h want 1 00000100", mem_req, mem_addr);
    end
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      tick();
      done = halted;
    end
    n_vec++;
    if (!done || mem[192] !== 32'd0 || mem[193] !== 32'd0) begin
      n_err++;
      $display("FAIL regs_cleared: got h=%b r1=%h r2=%h want 1 00000000 00000000", halted,
               mem[192], mem[193]);
    end
  endtask

`ifdef MIPS_MC_PERF_EN
  task automatic test_perf();
    clear_mem();
    for (int i = 0; i < 3; i++) mem[64 + i] = 32'h00221820;
    mem[67] = 32'h0000000D;
    ready = 1'b1;
    apply_reset();
    n_vec++;
    if (cycle_count !== 32'd0 || instret_count !== 32'd0) begin
      n_err++;
      $display("FAIL perf_reset: got cyc=%0d ret=%0d want 0 0", cycle_count, instret_count);
    end
    repeat (14) tick();
    n_vec++;
    if (halted !== 1'b1 || instret_count !== 32'd3 || cycle_count !== 32'd14) begin
      n_err++;
      $display("FAIL perf_halt: got h=%b ret=%0d cyc=%0d want 1 3 14", halted,
               instret_count, cycle_count);
    end
    repeat (5) tick();
    n_vec++;
    if (instret_count !== 32'd3 || cycle_count !== 32'd19) begin
      n_err++;
      $display("FAIL perf_halted_count: got ret=%0d cyc=%0d want 3 19", instret_count,
               cycle_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_wait_states();
    test_branch();
    test_faults();
    test_reset_stall();
`ifdef MIPS_MC_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
